// File: rtl/disp_pkg.sv
// Shared definitions for the display code bus.
// A digit code is 6 bits: [5] blink, [4] dot (0 lights the DP), [3:0] symbol.
// Eight codes are packed {led7, ..., led0}; led0 is the rightmost digit.
package disp_pkg;

  localparam int DIGIT_W    = 6;
  localparam int NUM_DIGITS = 8;

  localparam int BLINK_BIT = 5;
  localparam int DOT_BIT   = 4;
  localparam int CODE_MSB  = 3;

  localparam logic [CODE_MSB:0] CODE_DASH  = 4'd10;
  localparam logic [CODE_MSB:0] CODE_BLANK = 4'd15;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display code bus between the clock UI (master) and the scan driver (slave).
//   digits      : eight packed 6-bit digit codes, master -> slave
//   an          : digit enables, an[k] drives digit k
//   seg         : segments {g,f,e,d,c,b,a}
//   dp          : decimal point
//   frame_start : one-clock pulse when the driver snapshots digits
interface seg_scan_driver_if;
  import disp_pkg::*;

  logic [DIGIT_W*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]         an;
  logic [6:0]                    seg;
  logic                          dp;
  logic                          frame_start;

  modport master (output digits, input an, seg, dp, frame_start);
  modport slave  (input digits, output an, seg, dp, frame_start);

endinterface

// File: rtl/seg7_decode.sv
// Combinational symbol decoder.
//   code : 4-bit BCD/symbol code (0-9 digits, 10 dash, 11-15 blank)
//   seg  : active-high segments {g,f,e,d,c,b,a}
module seg7_decode
  import disp_pkg::*;
(
  input  logic [CODE_MSB:0] code,
  output logic [6:0]        seg
);

  always_comb begin
    seg = 7'b0000000;
    case (code)
      4'd0:      seg = 7'b0111111;
      4'd1:      seg = 7'b0000110;
      4'd2:      seg = 7'b1011011;
      4'd3:      seg = 7'b1001111;
      4'd4:      seg = 7'b1100110;
      4'd5:      seg = 7'b1101101;
      4'd6:      seg = 7'b1111101;
      4'd7:      seg = 7'b0000111;
      4'd8:      seg = 7'b1111111;
      4'd9:      seg = 7'b1101111;
      CODE_DASH: seg = 7'b1000000;
      4'd11, 4'd12, 4'd13, 4'd14, CODE_BLANK: seg = 7'b0000000;
      default:   seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the display code bus (digits in; an, seg, dp,
//                frame_start out, all registered)
// Each digit owns DIGIT_DIV clocks; the first DEAD_CYCLES of every slot are
// blanked to suppress ghosting. The eight codes are captured once per frame
// (idx 0, cnt 0) so a frame never mixes old and new values.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int DIGIT_DIV      = 100000,
  parameter int DEAD_CYCLES    = 1000,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int CW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FW = DIGIT_W * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD   = CW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Reset frame: symbol 0 with the dot off on every digit.
  localparam logic [DIGIT_W-1:0] IDLE_CODE = 6'b010000;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [2:0]              idx_reg, idx_next;
  logic [BW-1:0]           blink_cnt_reg, blink_cnt_next;
  logic                    blink_phase_reg, blink_phase_next;
  logic [FW-1:0]           frame_reg, frame_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic                    frame_start_reg, frame_start_next;

  logic [DIGIT_W-1:0]      codes [NUM_DIGITS];
  logic [DIGIT_W-1:0]      sel_code;
  logic [6:0]              seg_raw;
  logic                    snap, blank;
  logic [NUM_DIGITS-1:0]   an_hi;
  logic [6:0]              seg_hi;
  logic                    dp_hi;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_codes
    assign codes[gi] = frame_reg[gi*DIGIT_W +: DIGIT_W];
  end

  assign sel_code = codes[idx_reg];

  seg7_decode u_decode (
    .code (sel_code[CODE_MSB:0]),
    .seg  (seg_raw)
  );

  always_comb begin
    cnt_next         = cnt_reg + CW'(1);
    idx_next         = idx_reg;
    blink_cnt_next   = blink_cnt_reg + BW'(1);
    blink_phase_next = blink_phase_reg;
    frame_next       = frame_reg;

    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx_reg + 3'd1;
    end

    if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_next   = '0;
      blink_phase_next = ~blink_phase_reg;
    end

    snap = (idx_reg == 3'd0) && (cnt_reg == '0);
    if (snap) begin
      frame_next = bus.digits;
    end

    // Dead time and the hidden half of a blinking digit look identical.
    blank  = (cnt_reg < CNT_DEAD) || (sel_code[BLINK_BIT] && blink_phase_reg);
    an_hi  = blank ? '0 : (NUM_DIGITS'(1) << idx_reg);
    seg_hi = blank ? '0 : seg_raw;
    dp_hi  = ~blank & ~sel_code[DOT_BIT];

    an_next          = (AN_ACTIVE_LOW != 0) ? ~an_hi : an_hi;
    seg_next         = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dp_next          = (SEG_ACTIVE_LOW != 0) ? ~dp_hi : dp_hi;
    frame_start_next = snap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      frame_reg       <= {NUM_DIGITS{IDLE_CODE}};
      an_reg          <= AN_OFF;
      seg_reg         <= SEG_OFF;
      dp_reg          <= DP_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      frame_reg       <= frame_next;
      an_reg          <= an_next;
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign bus.an          = an_reg;
  assign bus.seg         = seg_reg;
  assign bus.dp          = dp_reg;
  assign bus.frame_start = frame_start_reg;

endmodule
